// File: rtl/pq_pkg.sv
// pq_pkg: shared op encoding and key ordering for the sorted priority queue.
package pq_pkg;

    typedef enum logic [1:0] {OP_NONE, OP_INS, OP_REM, OP_REPL} op_e;

    localparam int BEATS_W = 64;

    // Equal keys never beat, which keeps equal keys in arrival order.
    function automatic logic beats(input logic [BEATS_W-1:0] new_key,
                                   input logic [BEATS_W-1:0] old_key,
                                   input logic               max_first);
        return max_first ? (new_key > old_key) : (new_key < old_key);
    endfunction

endpackage

// File: rtl/pq_slot.sv
// pq_slot: one queue entry; picks hold, new, upper or lower neighbour each cycle.
module pq_slot
    import pq_pkg::*;
#(
    parameter int KEY_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  op_e               op,
    input  logic              up_v,
    input  logic [KEY_W-1:0]  up_k,
    input  logic [DATA_W-1:0] up_d,
    input  logic              lo_v,
    input  logic [KEY_W-1:0]  lo_k,
    input  logic [DATA_W-1:0] lo_d,
    input  logic [KEY_W-1:0]  new_k,
    input  logic [DATA_W-1:0] new_d,
    input  logic              bt,
    input  logic              bt_up,
    output logic              slot_v_q,
    output logic [KEY_W-1:0]  slot_k_q,
    output logic [DATA_W-1:0] slot_d_q
);

    logic              slot_v_d;
    logic [KEY_W-1:0]  slot_k_d;
    logic [DATA_W-1:0] slot_d_d;
    logic              take_new, take_up, take_lo;

    // In replace, bt compares against the lower neighbour (the up-shifted view).
    always_comb begin
        take_new = bt && !bt_up && (op == OP_INS || op == OP_REPL);
        take_up  = bt && bt_up && op == OP_INS;
        take_lo  = op == OP_REM || (op == OP_REPL && !bt);
        slot_v_d = flush ? 1'b0 : take_new ? 1'b1  : take_up ? up_v : take_lo ? lo_v : slot_v_q;
        slot_k_d = flush ? '0   : take_new ? new_k : take_up ? up_k : take_lo ? lo_k : slot_k_q;
        slot_d_d = flush ? '0   : take_new ? new_d : take_up ? up_d : take_lo ? lo_d : slot_d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_q <= 1'b0;
            slot_k_q <= '0;
            slot_d_q <= '0;
        end else begin
            slot_v_q <= slot_v_d;
            slot_k_q <= slot_k_d;
            slot_d_q <= slot_d_d;
        end
    end

endmodule

// File: rtl/pq_sorted_param.sv
// pq_sorted_param: parametrised shift-register priority queue with replace, flush
// and overflow/underflow pulses; slot 0 is always the head.
module pq_sorted_param
    import pq_pkg::*;
#(
    parameter int KEY_W     = 16,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter bit MAX_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       insert,
    input  logic [KEY_W-1:0]           ins_key,
    input  logic [DATA_W-1:0]          ins_data,
    input  logic                       remove,
    output logic                       head_valid,
    output logic [KEY_W-1:0]           head_key,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH+1);

    logic              v_q [DEPTH];
    logic [KEY_W-1:0]  k_q [DEPTH];
    logic [DATA_W-1:0] d_q [DEPTH];
    logic [DEPTH-1:0]  bt;
    op_e               op;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;

    assign full       = count_q == CW'(DEPTH);
    assign empty      = count_q == '0;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign head_valid = v_q[0];
    assign head_key   = v_q[0] ? k_q[0] : '0;
    assign head_data  = v_q[0] ? d_q[0] : '0;

    // Insert+remove on an empty queue degenerates to a plain insert.
    always_comb begin
        op      = flush ? OP_NONE
                : (insert && remove) ? (empty ? OP_INS : OP_REPL)
                : (insert && !full) ? OP_INS
                : (remove && !empty) ? OP_REM
                : OP_NONE;
        count_d = flush ? '0
                : op == OP_INS ? count_q + CW'(1)
                : op == OP_REM ? count_q - CW'(1)
                : count_q;
        ovf_d   = !flush && insert && !remove && full;
        unf_d   = !flush && remove && empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic              up_v, lo_v, bt_up;
        logic [KEY_W-1:0]  up_k, lo_k;
        logic [DATA_W-1:0] up_d, lo_d;

        if (i == 0) begin : g_top
            assign {up_v, up_k, up_d, bt_up} = '0;
        end else begin : g_mid
            assign {up_v, up_k, up_d} = {v_q[i-1], k_q[i-1], d_q[i-1]};
            assign bt_up              = bt[i-1];
        end

        if (i == DEPTH-1) begin : g_bot
            assign {lo_v, lo_k, lo_d} = '0;
        end else begin : g_low
            assign {lo_v, lo_k, lo_d} = {v_q[i+1], k_q[i+1], d_q[i+1]};
        end

        // An empty position is always beaten, so the new entry lands at the tail.
        assign bt[i] = (op == OP_REPL)
                     ? (!lo_v || beats(BEATS_W'(ins_key), BEATS_W'(lo_k), MAX_FIRST))
                     : (!v_q[i] || beats(BEATS_W'(ins_key), BEATS_W'(k_q[i]), MAX_FIRST));

        pq_slot #(.KEY_W(KEY_W), .DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .op       (op),
            .up_v     (up_v),
            .up_k     (up_k),
            .up_d     (up_d),
            .lo_v     (lo_v),
            .lo_k     (lo_k),
            .lo_d     (lo_d),
            .new_k    (ins_key),
            .new_d    (ins_data),
            .bt       (bt[i]),
            .bt_up    (bt_up),
            .slot_v_q (v_q[i]),
            .slot_k_q (k_q[i]),
            .slot_d_q (d_q[i])
        );
    end

endmodule
